sdf_butterfly_r2: RTL and testbench

Radix-2 single-delay-feedback (R2SDF) butterfly stage sitting directly downstream of the CSD twiddle multiplier in the N=128 pipeline. It consumes the multiplier's full-precision complex product, re-quantizes it back to working precision with round-half-up and saturation, and performs the next stage's add/subtract butterfly using an internal feedback delay line. It emits one complex sample per accepted input, in natural SDF order.

---
 rtl/sdf_butterfly_r2_pkg.sv | 43 ++++
 rtl/sdf_delay_line.sv | 39 +++
 rtl/sdf_butterfly_r2.sv | 123 ++++++++++++
 tb/tb_sdf_butterfly_r2.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sdf_butterfly_r2_pkg.sv
// Shared helpers for the SDF pipeline: complex packing,
// round-half-up with saturation, and phase counter width.
`ifndef SDF_BUTTERFLY_R2_PKG_SV
`define SDF_BUTTERFLY_R2_PKG_SV

`define CPLX_PACK(re, im) {re, im}
`define CPLX_RE(x, w) x[2*(w)-1:(w)]
`define CPLX_IM(x, w) x[(w)-1:0]

package sdf_butterfly_r2_pkg;

  localparam int DELAY_DEF = 32;
  localparam int CNT_W = $clog2(2*DELAY_DEF);

  // Returns {sat, y}; y is the clipped value, sign-extended to 32 bits.
  function automatic logic [32:0] rnd_sat(
    input logic signed [31:0] x,
    input int                 shift,
    input int                 nbits
  );
    logic signed [31:0] t;
    logic signed [31:0] y;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic               sat;
    t   = x + (32'sd1 <<< (shift - 1));
    y   = t >>> shift;
    hi  = (32'sd1 <<< (nbits - 1)) - 32'sd1;
    lo  = -(32'sd1 <<< (nbits - 1));
    sat = 1'b0;
    if (y > hi) begin
      y   = hi;
      sat = 1'b1;
    end else if (y < lo) begin
      y   = lo;
      sat = 1'b1;
    end
    return {sat, y};
  endfunction

endpackage

`endif

// File: rtl/sdf_delay_line.sv
// Enabled shift register; new data enters at the tail,
// head is the oldest entry.
module sdf_delay_line #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (en) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      mem_d[DEPTH-1] = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign head = mem_q[0];

endmodule

// File: rtl/sdf_butterfly_r2.sv
// R2SDF butterfly stage: re-quantizes the twiddle product,
// then sum/difference against the feedback delay line.
module sdf_butterfly_r2
  import sdf_butterfly_r2_pkg::*;
#(
  parameter int NBITS_IN = 24,
  parameter int NBITS    = 12,
  parameter int SHIFT    = 9,
  parameter int DELAY    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*NBITS_IN-1:0]   muestra,
  input  logic                    in_valid,
  output logic [2*(NBITS+1)-1:0]  result,
  output logic                    out_valid,
  output logic                    half,
  output logic                    sat_flag
);

  localparam int W  = NBITS + 1;
  localparam int CW = $clog2(2*DELAY);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic               primed_q, primed_d;
  logic [2*W-1:0]     result_q, result_d;
  logic               out_valid_q, out_valid_d;
  logic               half_q, half_d;
  logic               sat_q, sat_d;

  logic signed [31:0] x_re, x_im;
  logic [32:0]        rs_re, rs_im;
  logic signed [W-1:0] b_re, b_im;
  logic signed [W-1:0] a_re, a_im;
  logic signed [W-1:0] sum_re, sum_im;
  logic signed [W-1:0] dif_re, dif_im;
  logic [2*W-1:0]     head;
  logic [2*W-1:0]     push;
  logic [2*W-1:0]     out_val;
  logic               phase;
  logic               unused_rs;

  assign x_re = 32'($signed(`CPLX_RE(muestra, NBITS_IN)));
  assign x_im = 32'($signed(`CPLX_IM(muestra, NBITS_IN)));

  assign rs_re = rnd_sat(x_re, SHIFT, NBITS);
  assign rs_im = rnd_sat(x_im, SHIFT, NBITS);
  assign unused_rs = ^{rs_re[31:NBITS], rs_im[31:NBITS]};

  assign b_re = W'($signed(rs_re[NBITS-1:0]));
  assign b_im = W'($signed(rs_im[NBITS-1:0]));

  assign a_re = $signed(`CPLX_RE(head, W));
  assign a_im = $signed(`CPLX_IM(head, W));

  assign sum_re = a_re + b_re;
  assign sum_im = a_im + b_im;
  assign dif_re = a_re - b_re;
  assign dif_im = a_im - b_im;

  assign phase = cnt_q[CW-1];

  always_comb begin
    push    = `CPLX_PACK(b_re, b_im);
    out_val = head;
    if (phase) begin
      push    = `CPLX_PACK(dif_re, dif_im);
      out_val = `CPLX_PACK(sum_re, sum_im);
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    primed_d    = primed_q;
    result_d    = result_q;
    half_d      = half_q;
    out_valid_d = 1'b0;
    sat_d       = sat_q;
    if (in_valid) begin
      cnt_d       = cnt_q + 1'b1;
      primed_d    = primed_q | phase;
      result_d    = out_val;
      half_d      = phase;
      out_valid_d = phase | primed_q;
      sat_d       = sat_q | rs_re[32] | rs_im[32];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      half_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      half_q      <= half_d;
      sat_q       <= sat_d;
    end
  end

  sdf_delay_line #(
    .WIDTH (2*W),
    .DEPTH (DELAY)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst),
    .en    (in_valid),
    .din   (push),
    .head  (head)
  );

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign half      = half_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_sdf_butterfly_r2.sv
// Directed bench for sdf_butterfly_r2 with DELAY=4:
// butterfly, gaps, rounding, saturation, growth, reset.
module tb_sdf_butterfly_r2;

  localparam int NI = 24;
  localparam int N  = 12;
  localparam int SH = 9;
  localparam int D  = 4;
  localparam int W  = N + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [2*NI-1:0] muestra = '0;
  logic [2*W-1:0]  result;
  logic            out_valid;
  logic            half;
  logic            sat_flag;

  int errs = 0;
  int checks = 0;

  wire signed [W-1:0] r_re = result[2*W-1:W];
  wire signed [W-1:0] r_im = result[W-1:0];

  always #5 clk = ~clk;

  sdf_butterfly_r2 #(
    .NBITS_IN (NI),
    .NBITS    (N),
    .SHIFT    (SH),
    .DELAY    (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .muestra   (muestra),
    .in_valid  (in_valid),
    .result    (result),
    .out_valid (out_valid),
    .half      (half),
    .sat_flag  (sat_flag)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic v, input int re, input int im);
    @(negedge clk);
    in_valid = v;
    muestra  = {re[NI-1:0], im[NI-1:0]};
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  int bf_in [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 1, 2, 3, 4};
  int bf_ov [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
  int bf_re [12] = '{0, 0, 0, 0, 6, 8, 10, 12, -4, -4, -4, -4};
  int bf_hf [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  int rd_in [4]  = '{256, -256, 767, 768};
  int rd_q  [4]  = '{1, 0, 1, 2};
  int gw_in [4]  = '{2047, -2048, 0, 0};
  int gw_sum[4]  = '{4094, -1, 2047, 2047};
  int gw_dif[4]  = '{0, 4095, 2047, 2047};
  int last;
  int gaps;

  initial begin
    #2 rst = 1'b0;
    #10;
    check("rst_result", int'(result), 0);
    check("rst_ov", int'(out_valid), 0);
    check("rst_half", int'(half), 0);
    check("rst_sat", int'(sat_flag), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      xfer(1'b1, 512 * bf_in[i], 0);
      check("bf_ov", int'(out_valid), bf_ov[i]);
      check("bf_re", int'(r_re), bf_re[i]);
      check("bf_im", int'(r_im), 0);
      check("bf_half", int'(half), bf_hf[i]);
    end

    do_reset();
    last = 0;
    for (int i = 0; i < 12; i++) begin
      gaps = int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        xfer(1'b0, 0, 0);
        check("gap_ov", int'(out_valid), 0);
        check("gap_hold", int'(r_re), last);
      end
      xfer(1'b1, 512 * bf_in[i], 0);
      check("gap_bf_ov", int'(out_valid), bf_ov[i]);
      check("gap_bf_re", int'(r_re), bf_re[i]);
      check("gap_bf_half", int'(half), bf_hf[i]);
      last = bf_re[i];
    end

    do_reset();
    for (int i = 0; i < D; i++) xfer(1'b1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, rd_in[i], 0);
      check("rnd_q", int'(r_re), rd_q[i]);
    end
    check("rnd_nosat", int'(sat_flag), 0);

    do_reset();
    for (int i = 0; i < D; i++) xfer(1'b1, 0, 0);
    xfer(1'b1, 'h7FFFFF, 'h800000);
    check("sat_hi", int'(r_re), 2047);
    check("sat_lo", int'(r_im), -2048);
    check("sat_flag", int'(sat_flag), 1);
    xfer(1'b0, 0, 0);
    xfer(1'b0, 0, 0);
    check("sat_sticky", int'(sat_flag), 1);
    xfer(1'b1, 0, 0);
    check("sat_sticky2", int'(sat_flag), 1);
    check("pre_rst_ov", int'(out_valid), 1);
    check("pre_rst_half", int'(half), 1);

    @(negedge clk);
    in_valid = 1'b1;
    muestra  = '0;
    #1 rst = 1'b0;
    #1;
    check("arst_result", int'(result), 0);
    check("arst_ov", int'(out_valid), 0);
    check("arst_half", int'(half), 0);
    check("arst_sat", int'(sat_flag), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("arst_first_supp", int'(out_valid), 0);

    do_reset();
    for (int i = 0; i < D; i++) xfer(1'b1, 2047 * 512, 0);
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, gw_in[i] * 512, 0);
      check("grow_sum", int'(r_re), gw_sum[i]);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 0, 0);
      check("grow_dif", int'(r_re), gw_dif[i]);
      check("grow_half", int'(half), 0);
    end
    xfer(1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
